// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory arbiter and its init sequencer.
package dmem_ctrl_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam int RAM_SIZE_DEF = 2048;

  // Observation bundle: FSM state, current memory owner, starvation counter.
  typedef struct packed {
    state_t     state;
    logic       owner;
    logic [7:0] wait_cnt;
  } dbg_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, DMA and memory-side signals of the data-memory arbiter.
// DMA handshake: dma_req (with dma_we/addr/wdata) is held stable until dma_gnt; the access happens in the cycle both are high.
interface dmem_arbiter_if;
  logic        cpu_mem_read;
  logic        cpu_mem_write;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_gnt;
  logic [31:0] dma_rdata;
  logic        dma_rvalid;

  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        init_done;

  modport slave (
    input  cpu_mem_read, cpu_mem_write, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata,
    output init_done
  );

  modport master (
    output cpu_mem_read, cpu_mem_write, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata,
    input  init_done
  );
endinterface

// File: rtl/dmem_init_seq.sv
// Post-reset scratch-clear sequencer: walks INIT_WORDS word indices from INIT_BASE, one per cycle.
module dmem_init_seq
  import dmem_ctrl_pkg::*;
#(
  parameter int RAM_SIZE   = RAM_SIZE_DEF,
  parameter int INIT_BASE  = 1024,
  parameter int INIT_WORDS = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active_o,
  output logic        last_o,
  output logic        done_o,
  output logic [31:0] addr_o
);
  localparam int IW = (INIT_WORDS > 1) ? $clog2(INIT_WORDS) : 1;
  localparam int AW = $clog2(RAM_SIZE);
  localparam logic [IW-1:0] LAST_IDX = IW'(INIT_WORDS - 1);

  logic [IW-1:0] idx_q, idx_d;
  logic          done_q, done_d;
  logic [AW-1:0] word;

  always_comb begin
    active_o = !done_q;
    last_o   = active_o && (idx_q == LAST_IDX);
    idx_d    = idx_q;
    done_d   = done_q;
    if (active_o) begin
      idx_d  = last_o ? '0 : idx_q + 1'b1;
      done_d = last_o;
    end
    word   = AW'(INIT_BASE) + AW'(idx_q);
    addr_o = {{(30 - AW){1'b0}}, word, 2'b00};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q  <= '0;
      done_q <= (INIT_WORDS == 0);
    end else begin
      idx_q  <= idx_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the MEM stage and a DMA port:
// clears a scratch region after reset, then grants per cycle with CPU priority and a bounded DMA wait.
module dmem_arbiter
  import dmem_ctrl_pkg::*;
#(
  parameter int RAM_SIZE   = RAM_SIZE_DEF,
  parameter int INIT_BASE  = 1024,
  parameter int INIT_WORDS = 16,
  parameter int MAX_WAIT   = 4
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus,
  output dbg_t           dbg_o
);
  localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WW-1:0] WAIT_MAX    = WW'(MAX_WAIT);
  localparam state_t        RESET_STATE = (INIT_WORDS == 0) ? ST_RUN : ST_INIT;

  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          rvalid_q;
  logic [31:0]   rdata_q;

  logic          cpu_act, force_gnt, gnt, owner;
  logic          init_active, init_last, init_done_w;
  logic [31:0]   init_addr;

  dmem_init_seq #(
    .RAM_SIZE  (RAM_SIZE),
    .INIT_BASE (INIT_BASE),
    .INIT_WORDS(INIT_WORDS)
  ) u_init (
    .clk     (clk),
    .reset   (reset),
    .active_o(init_active),
    .last_o  (init_last),
    .done_o  (init_done_w),
    .addr_o  (init_addr)
  );

  always_comb begin
    state_d       = state_q;
    wait_d        = '0;
    owner         = OWN_CPU;
    gnt           = 1'b0;
    cpu_act       = bus.cpu_mem_read || bus.cpu_mem_write;
    force_gnt     = bus.dma_req && (wait_q == WAIT_MAX);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.cpu_stall = 1'b1;
    bus.cpu_rdata = '0;
    case (state_q)
      ST_INIT: begin
        bus.mem_write = init_active;
        bus.mem_addr  = init_addr;
        if (init_last) state_d = ST_RUN;
      end
      ST_RUN: begin
        gnt = bus.dma_req && (!cpu_act || force_gnt);
        if (gnt) begin
          owner         = OWN_DMA;
          bus.mem_read  = !bus.dma_we;
          bus.mem_write = bus.dma_we;
          bus.mem_addr  = bus.dma_addr;
          bus.mem_wdata = bus.dma_wdata;
          bus.cpu_stall = cpu_act;
        end else begin
          bus.mem_read  = bus.cpu_mem_read;
          bus.mem_write = bus.cpu_mem_write;
          bus.mem_addr  = bus.cpu_addr;
          bus.mem_wdata = bus.cpu_wdata;
          bus.cpu_rdata = bus.cpu_mem_read ? bus.mem_rdata : '0;
          bus.cpu_stall = 1'b0;
        end
        // A refused request ages; a forced grant never coexists with a refusal, so this saturates.
        if (bus.dma_req && !gnt) wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
      end
      default: state_d = RESET_STATE;
    endcase
    bus.dma_gnt = gnt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RESET_STATE;
      wait_q   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      rvalid_q <= gnt && !bus.dma_we;
      if (gnt && !bus.dma_we) rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.dma_rdata  = rdata_q;
  assign bus.dma_rvalid = rvalid_q;
  assign bus.init_done  = init_done_w;
  assign dbg_o          = '{state: state_q, owner: owner, wait_cnt: 8'(wait_q)};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port RAM (combinational read).
module tb_dmem_arbiter;
  import dmem_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();
  dbg_t dbg;

  dmem_arbiter #(
    .RAM_SIZE  (2048),
    .INIT_BASE (1024),
    .INIT_WORDS(16),
    .MAX_WAIT  (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .dbg_o(dbg)
  );

  logic [31:0] ram [0:2047];
  assign bus.mem_rdata = ram[bus.mem_addr[12:2]];
  always @(posedge clk) if (bus.mem_write) ram[bus.mem_addr[12:2]] <= bus.mem_wdata;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic idle_inputs();
    bus.cpu_mem_read  = 1'b0;
    bus.cpu_mem_write = 1'b0;
    bus.cpu_addr      = '0;
    bus.cpu_wdata     = '0;
    bus.dma_req       = 1'b0;
    bus.dma_we        = 1'b0;
    bus.dma_addr      = '0;
    bus.dma_wdata     = '0;
  endtask

  task automatic test_reset();
    int bad;
    idle_inputs();
    for (int i = 0; i < 2048; i++) ram[i] = 32'hDEAD_0000 | 32'(i);
    ram[5] = 32'hFFFF_FFFF;
    ram[8] = 32'h1234_5678;
    #12;
    n_cmp++;
    if ({bus.init_done, bus.dma_rvalid, bus.dma_rdata, dbg.state, dbg.wait_cnt} !== {1'b0, 1'b0, 32'h0, ST_INIT, 8'h0}) begin
      n_fail++;
      $display("FAIL reset_values: done=%b rvalid=%b rdata=%h state=%b wait=%0d, want 0 0 00000000 0 0",
               bus.init_done, bus.dma_rvalid, bus.dma_rdata, dbg.state, dbg.wait_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    bus.cpu_mem_read = 1'b1;
    bus.dma_req = 1'b1;
    bus.dma_we = 1'b1;
    bus.dma_addr = 32'h0000_2000;
    bus.dma_wdata = 32'hCAFE_CAFE;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_cmp++;
      if ({bus.mem_write, bus.mem_read, bus.cpu_stall, bus.dma_gnt, bus.init_done} !== 5'b10100 ||
          bus.mem_addr !== 32'h1000 + 32'(4 * i) || bus.mem_wdata !== 32'h0 || bus.cpu_rdata !== 32'h0 ||
          dbg.wait_cnt !== 8'h0) begin
        n_fail++;
        $display("FAIL init_cycle %0d: we/re/stall/gnt/done=%b%b%b%b%b addr=%h wdata=%h rdata=%h wait=%0d, want 10100 %h 0 0 0",
                 i, bus.mem_write, bus.mem_read, bus.cpu_stall, bus.dma_gnt, bus.init_done, bus.mem_addr,
                 bus.mem_wdata, bus.cpu_rdata, dbg.wait_cnt, 32'h1000 + 32'(4 * i));
      end
      @(posedge clk);
    end
    #1 idle_inputs();
    @(negedge clk);
    n_cmp++;
    if ({bus.init_done, dbg.state, dbg.wait_cnt, bus.cpu_stall} !== {1'b1, ST_RUN, 8'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL init_done: done=%b state=%b wait=%0d stall=%b, want 1 1 0 0",
               bus.init_done, dbg.state, dbg.wait_cnt, bus.cpu_stall);
    end
    bad = 0;
    for (int j = 1024; j < 1040; j++) if (ram[j] !== 32'h0) bad++;
    n_cmp++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL init_cleared: %0d nonzero words, want 0", bad);
    end
    n_cmp++;
    if (ram[1023] !== 32'hDEAD_03FF || ram[1040] !== 32'hDEAD_0410) begin
      n_fail++;
      $display("FAIL init_bounds: ram[1023]=%h ram[1040]=%h, want DEAD03FF DEAD0410", ram[1023], ram[1040]);
    end
  endtask

  task automatic test_dma_read_idle();
    @(negedge clk);
    bus.dma_req = 1'b1;
    bus.dma_we = 1'b0;
    bus.dma_addr = 32'h0000_0014;
    #1;
    n_cmp++;
    if ({bus.dma_gnt, bus.mem_read, bus.mem_write, bus.cpu_stall, bus.dma_rvalid} !== 5'b11000 || bus.mem_addr !== 32'h14) begin
      n_fail++;
      $display("FAIL dma_read_grant: gnt/re/we/stall/rvalid=%b%b%b%b%b addr=%h, want 11000 00000014",
               bus.dma_gnt, bus.mem_read, bus.mem_write, bus.cpu_stall, bus.dma_rvalid, bus.mem_addr);
    end
    @(posedge clk);
    #1 bus.dma_req = 1'b0;
    n_cmp++;
    if (bus.dma_rvalid !== 1'b1 || bus.dma_rdata !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL dma_read_data: rvalid=%b rdata=%h, want 1 FFFFFFFF", bus.dma_rvalid, bus.dma_rdata);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.dma_rvalid !== 1'b0 || bus.dma_rdata !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL dma_rvalid_pulse: rvalid=%b rdata=%h, want 0 FFFFFFFF", bus.dma_rvalid, bus.dma_rdata);
    end
  endtask

  task automatic test_starvation();
    @(negedge clk);
    bus.cpu_mem_read = 1'b1;
    bus.cpu_addr = 32'h0000_0020;
    bus.dma_req = 1'b1;
    bus.dma_we = 1'b1;
    bus.dma_addr = 32'h0000_1004;
    bus.dma_wdata = 32'hA5A5_A5A5;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++;
      if (k < 4) begin
        if ({bus.dma_gnt, bus.cpu_stall} !== 2'b00 || bus.cpu_rdata !== 32'h1234_5678 ||
            bus.mem_addr !== 32'h20 || dbg.wait_cnt !== 8'(k)) begin
          n_fail++;
          $display("FAIL starve_refuse %0d: gnt=%b stall=%b rdata=%h addr=%h wait=%0d, want 0 0 12345678 00000020 %0d",
                   k, bus.dma_gnt, bus.cpu_stall, bus.cpu_rdata, bus.mem_addr, dbg.wait_cnt, k);
        end
      end else begin
        if ({bus.dma_gnt, bus.cpu_stall, bus.mem_write, bus.mem_read} !== 4'b1110 || bus.cpu_rdata !== 32'h0 ||
            bus.mem_addr !== 32'h1004 || bus.mem_wdata !== 32'hA5A5_A5A5 || dbg.wait_cnt !== 8'd4) begin
          n_fail++;
          $display("FAIL starve_force: gnt/stall/we/re=%b%b%b%b rdata=%h addr=%h wdata=%h wait=%0d, want 1110 0 1004 A5A5A5A5 4",
                   bus.dma_gnt, bus.cpu_stall, bus.mem_write, bus.mem_read, bus.cpu_rdata, bus.mem_addr,
                   bus.mem_wdata, dbg.wait_cnt);
        end
      end
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if ({bus.dma_gnt, bus.cpu_stall, bus.dma_rvalid} !== 3'b000 || dbg.wait_cnt !== 8'd0 || ram[1025] !== 32'hA5A5_A5A5) begin
      n_fail++;
      $display("FAIL starve_after: gnt=%b stall=%b rvalid=%b wait=%0d ram=%h, want 0 0 0 0 A5A5A5A5",
               bus.dma_gnt, bus.cpu_stall, bus.dma_rvalid, dbg.wait_cnt, ram[1025]);
    end
    idle_inputs();
    @(negedge clk);
    bus.dma_req = 1'b1;
    bus.dma_addr = 32'h0000_1004;
    #1;
    n_cmp++;
    if (bus.dma_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL readback_grant: gnt=%b, want 1", bus.dma_gnt);
    end
    @(posedge clk);
    #1 bus.dma_req = 1'b0;
    n_cmp++;
    if (bus.dma_rvalid !== 1'b1 || bus.dma_rdata !== 32'hA5A5_A5A5) begin
      n_fail++;
      $display("FAIL readback_data: rvalid=%b rdata=%h, want 1 A5A5A5A5", bus.dma_rvalid, bus.dma_rdata);
    end
  endtask

  task automatic test_same_addr();
    @(negedge clk);
    bus.cpu_mem_write = 1'b1;
    bus.cpu_addr = 32'h0000_1008;
    bus.cpu_wdata = 32'h1111_1111;
    bus.dma_req = 1'b1;
    bus.dma_we = 1'b1;
    bus.dma_addr = 32'h0000_1008;
    bus.dma_wdata = 32'h2222_2222;
    #1;
    n_cmp++;
    if ({bus.dma_gnt, bus.cpu_stall, bus.mem_write} !== 3'b001 || bus.mem_wdata !== 32'h1111_1111) begin
      n_fail++;
      $display("FAIL same_addr_owner: gnt=%b stall=%b we=%b wdata=%h, want 0 0 1 11111111",
               bus.dma_gnt, bus.cpu_stall, bus.mem_write, bus.mem_wdata);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (ram[1026] !== 32'h1111_1111 || dbg.wait_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL same_addr_store: ram=%h wait=%0d, want 11111111 1", ram[1026], dbg.wait_cnt);
    end
    idle_inputs();
    @(posedge clk);
    #1;
    n_cmp++;
    if (ram[1026] !== 32'h1111_1111 || dbg.wait_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL wait_clear: ram=%h wait=%0d, want 11111111 0", ram[1026], dbg.wait_cnt);
    end
  endtask

  task automatic test_cpu_rw_both();
    @(negedge clk);
    bus.cpu_mem_read = 1'b1;
    bus.cpu_mem_write = 1'b1;
    bus.cpu_addr = 32'h0000_100C;
    bus.cpu_wdata = 32'h0000_0033;
    #1;
    n_cmp++;
    if ({bus.mem_read, bus.mem_write, bus.cpu_stall} !== 3'b110 || bus.mem_wdata !== 32'h33 || bus.mem_addr !== 32'h100C) begin
      n_fail++;
      $display("FAIL cpu_rw_both: re/we/stall=%b%b%b wdata=%h addr=%h, want 110 00000033 0000100C",
               bus.mem_read, bus.mem_write, bus.cpu_stall, bus.mem_wdata, bus.mem_addr);
    end
    @(posedge clk);
    #1 idle_inputs();
    n_cmp++;
    if (ram[1027] !== 32'h33) begin
      n_fail++;
      $display("FAIL cpu_rw_store: ram=%h, want 00000033", ram[1027]);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.dma_req = 1'b1;
    bus.dma_we = 1'b1;
    bus.dma_addr = 32'h0000_1010;
    bus.dma_wdata = 32'h0000_0044;
    #1;
    n_cmp++;
    if (bus.dma_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: gnt=%b, want 1", bus.dma_gnt);
    end
    @(negedge clk);
    bus.dma_addr = 32'h0000_1014;
    bus.dma_wdata = 32'h0000_0055;
    #1;
    n_cmp++;
    if (bus.dma_gnt !== 1'b1 || bus.dma_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: gnt=%b rvalid=%b, want 1 0", bus.dma_gnt, bus.dma_rvalid);
    end
    @(posedge clk);
    #1 idle_inputs();
    n_cmp++;
    if (ram[1028] !== 32'h44 || ram[1029] !== 32'h55) begin
      n_fail++;
      $display("FAIL b2b_store: ram=%h %h, want 00000044 00000055", ram[1028], ram[1029]);
    end
  endtask

  task automatic test_reset_mid_init();
    int cnt;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus.init_done, dbg.state} !== {1'b0, ST_INIT} || bus.mem_addr !== 32'h1000) begin
      n_fail++;
      $display("FAIL reset_in_run: done=%b state=%b addr=%h, want 0 0 00001000", bus.init_done, dbg.state, bus.mem_addr);
    end
    for (int j = 1024; j < 1040; j++) ram[j] = 32'hBAD0_0000 | 32'(j);
    @(negedge clk);
    reset = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.mem_addr !== 32'h101C || bus.init_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_init_idx7: addr=%h done=%b, want 0000101C 0", bus.mem_addr, bus.init_done);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (bus.mem_addr !== 32'h1000 || bus.init_done !== 1'b0 || dbg.state !== ST_INIT) begin
      n_fail++;
      $display("FAIL mid_init_restart: addr=%h done=%b state=%b, want 00001000 0 0", bus.mem_addr, bus.init_done, dbg.state);
    end
    #1 reset = 1'b1;
    cnt = 0;
    while (bus.init_done !== 1'b1 && cnt < 40) begin
      @(posedge clk);
      #1 cnt++;
    end
    n_cmp++;
    if (cnt !== 16 || ram[1039] !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_init_length: edges=%0d ram[1039]=%h, want 16 00000000", cnt, ram[1039]);
    end
  endtask

  task automatic test_reset_drops_rvalid();
    int cnt;
    int seen;
    @(negedge clk);
    bus.dma_req = 1'b1;
    bus.dma_we = 1'b0;
    bus.dma_addr = 32'h0000_0014;
    #1;
    n_cmp++;
    if (bus.dma_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_grant: gnt=%b, want 1", bus.dma_gnt);
    end
    #1 reset = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.dma_rvalid !== 1'b0 || bus.dma_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL drop_rvalid: rvalid=%b rdata=%h, want 0 00000000", bus.dma_rvalid, bus.dma_rdata);
    end
    @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    seen = 0;
    while (bus.init_done !== 1'b1 && cnt < 40) begin
      @(posedge clk);
      #1 cnt++;
      if (bus.dma_rvalid !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen !== 0 || bus.init_done !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_after: rvalid_cycles=%0d done=%b, want 0 1", seen, bus.init_done);
    end
  endtask

  initial begin
    test_reset();
    test_dma_read_idle();
    test_starvation();
    test_same_addr();
    test_cpu_rw_both();
    test_back_to_back();
    test_reset_mid_init();
    test_reset_drops_rvalid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
